// File: rtl/pmsm_position_sensor_emulator_module_pkg.sv
// Shared constants, quadrature state encoding and the hall sector lookup
// for the PMSM position-sensor emulator.
package pmsm_position_sensor_emulator_module_pkg;

    localparam int PMSM_POLE_PAIRS       = 4;
    localparam int INCREMENTAL_CODER_CPR = 1024;
    localparam int DATA_WIDTH            = 16;
    localparam int PHASE_WIDTH           = 14;

    // Sector boundaries on the 14-bit angle; the first sector starts at 0 and the last ends at 0x4000.
    localparam logic [PHASE_WIDTH-1:0] HALL_BOUND_0 = 14'h0000;
    localparam logic [PHASE_WIDTH-1:0] HALL_BOUND_1 = 14'h0AAA;
    localparam logic [PHASE_WIDTH-1:0] HALL_BOUND_2 = 14'h1555;
    localparam logic [PHASE_WIDTH-1:0] HALL_BOUND_3 = 14'h2000;
    localparam logic [PHASE_WIDTH-1:0] HALL_BOUND_4 = 14'h2AAA;
    localparam logic [PHASE_WIDTH-1:0] HALL_BOUND_5 = 14'h3555;

    localparam logic [2:0] HALL_RESET = 3'b101;

    // Encoding chosen so the state bits are the {A,B} outputs directly.
    typedef enum logic [1:0] {
        QUAD_00 = 2'b00,
        QUAD_10 = 2'b10,
        QUAD_11 = 2'b11,
        QUAD_01 = 2'b01
    } quad_state_e;

    function automatic logic [2:0] hallFromPhase(input logic [PHASE_WIDTH-1:0] phase);
        logic [2:0] hall;
        if (phase < HALL_BOUND_1)      hall = 3'b101;
        else if (phase < HALL_BOUND_2) hall = 3'b100;
        else if (phase < HALL_BOUND_3) hall = 3'b110;
        else if (phase < HALL_BOUND_4) hall = 3'b010;
        else if (phase < HALL_BOUND_5) hall = 3'b011;
        else                           hall = 3'b001;
        return hall;
    endfunction

endpackage

// File: rtl/pmsm_position_sensor_emulator_module_if.sv
// Command and sensor-output bundle between the emulator and its driver.
interface pmsm_position_sensor_emulator_module_if #(
    parameter int PERIOD_WIDTH = 24
);
    import pmsm_position_sensor_emulator_module_pkg::*;

    logic                    emulator_enable_in;
    logic                    rotate_direction_in;
    logic [PERIOD_WIDTH-1:0] step_period_in;
    logic                    phase_load_in;
    logic [PHASE_WIDTH-1:0]  phase_init_in;

    logic                    hall_u_out;
    logic                    hall_v_out;
    logic                    hall_w_out;
    logic                    heds_9040_a_out;
    logic                    heds_9040_b_out;
    logic                    heds_9040_decoder_out;
    logic                    heds_9040_index_out;
    logic [DATA_WIDTH-1:0]   model_phase_out;
    logic                    step_strobe_out;

    modport master (
        output emulator_enable_in, rotate_direction_in, step_period_in,
               phase_load_in, phase_init_in,
        input  hall_u_out, hall_v_out, hall_w_out, heds_9040_a_out,
               heds_9040_b_out, heds_9040_decoder_out, heds_9040_index_out,
               model_phase_out, step_strobe_out
    );

    modport slave (
        input  emulator_enable_in, rotate_direction_in, step_period_in,
               phase_load_in, phase_init_in,
        output hall_u_out, hall_v_out, hall_w_out, heds_9040_a_out,
               heds_9040_b_out, heds_9040_decoder_out, heds_9040_index_out,
               model_phase_out, step_strobe_out
    );

endinterface

// File: rtl/pmsm_position_sensor_emulator_module_quad.sv
// Step timer, quadrature FSM, decoder toggle and mechanical counter with
// its once-per-revolution index.
module quadrature_step_generator_module
    import pmsm_position_sensor_emulator_module_pkg::*;
#(
    parameter int CODER_CPR    = INCREMENTAL_CODER_CPR,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    direction_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    load_i,
    output logic                    step_o,
    output logic                    strobe_o,
    output logic                    a_o,
    output logic                    b_o,
    output logic                    decoder_o,
    output logic                    index_o
);

    localparam int MECH_STEPS = 4 * CODER_CPR;
    localparam int MECH_WIDTH = $clog2(MECH_STEPS);
    localparam logic [MECH_WIDTH-1:0]   MECH_LAST = MECH_WIDTH'(MECH_STEPS - 1);
    localparam logic [MECH_WIDTH-1:0]   MECH_ONE  = MECH_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] TIMER_ONE = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    quad_state_e             quad_q, quad_d;
    logic                    decoder_q, decoder_d;
    logic [MECH_WIDTH-1:0]   mech_q, mech_d;
    logic                    index_q, index_d;
    logic                    strobe_q, strobe_d;
    logic                    step;

    // A shrunken period that the timer already passed clears it without a step.
    always_comb begin
        timer_d = timer_q;
        step    = 1'b0;
        if (load_i) begin
            timer_d = '0;
        end else if (enable_i && (period_i != '0)) begin
            if (timer_q == period_i - TIMER_ONE) begin
                timer_d = '0;
                step    = 1'b1;
            end else if (timer_q >= period_i) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TIMER_ONE;
            end
        end
    end

    always_comb begin
        quad_d    = quad_q;
        decoder_d = decoder_q;
        mech_d    = mech_q;
        if (load_i) begin
            mech_d = '0;
        end else if (step) begin
            decoder_d = ~decoder_q;
            if (!direction_i) begin
                case (quad_q)
                    QUAD_00: quad_d = QUAD_10;
                    QUAD_10: quad_d = QUAD_11;
                    QUAD_11: quad_d = QUAD_01;
                    default: quad_d = QUAD_00;
                endcase
                mech_d = (mech_q == MECH_LAST) ? '0 : mech_q + MECH_ONE;
            end else begin
                case (quad_q)
                    QUAD_00: quad_d = QUAD_01;
                    QUAD_01: quad_d = QUAD_11;
                    QUAD_11: quad_d = QUAD_10;
                    default: quad_d = QUAD_00;
                endcase
                mech_d = (mech_q == '0) ? MECH_LAST : mech_q - MECH_ONE;
            end
        end
        index_d  = (mech_d == '0);
        strobe_d = step;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            quad_q    <= QUAD_00;
            decoder_q <= 1'b0;
            mech_q    <= '0;
            index_q   <= 1'b1;
            strobe_q  <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            quad_q    <= quad_d;
            decoder_q <= decoder_d;
            mech_q    <= mech_d;
            index_q   <= index_d;
            strobe_q  <= strobe_d;
        end
    end

    assign step_o    = step;
    assign strobe_o  = strobe_q;
    assign a_o       = quad_q[1];
    assign b_o       = quad_q[0];
    assign decoder_o = decoder_q;
    assign index_o   = index_q;

endmodule

// File: rtl/pmsm_position_sensor_emulator_module.sv
// Top level: electrical phase accumulator and hall encoder, driven by the
// step generator so every position output moves on the same edge.
module pmsm_position_sensor_emulator_module
    import pmsm_position_sensor_emulator_module_pkg::*;
#(
    parameter int POLE_PAIRS   = PMSM_POLE_PAIRS,
    parameter int CODER_CPR    = INCREMENTAL_CODER_CPR,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                                   sys_clk,
    input  logic                                   reset_n,
    pmsm_position_sensor_emulator_module_if.slave  emu
);

    localparam int DELTA_PHASE = 2 * POLE_PAIRS * 2048 / CODER_CPR;
    localparam int DELTA_SAFE  = (DELTA_PHASE == 0) ? 1 : DELTA_PHASE;
    localparam logic [PHASE_WIDTH-1:0] DELTA = PHASE_WIDTH'(DELTA_PHASE);

    // The accumulator must close exactly on one electrical turn.
    generate
        if ((DELTA_PHASE == 0) || ((16384 % DELTA_SAFE) != 0)) begin : g_bad_delta
            $error("DELTA_PHASE must be nonzero and divide 16384");
        end
    endgenerate

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [2:0]             hall_q, hall_d;
    logic                   step;
    logic                   quad_a, quad_b, decoder, index, strobe;

    quadrature_step_generator_module #(
        .CODER_CPR    (CODER_CPR),
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_step_gen (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .enable_i    (emu.emulator_enable_in),
        .direction_i (emu.rotate_direction_in),
        .period_i    (emu.step_period_in),
        .load_i      (emu.phase_load_in),
        .step_o      (step),
        .strobe_o    (strobe),
        .a_o         (quad_a),
        .b_o         (quad_b),
        .decoder_o   (decoder),
        .index_o     (index)
    );

    // Hall is encoded from the next phase so it registers alongside it.
    always_comb begin
        phase_d = phase_q;
        if (emu.phase_load_in) begin
            phase_d = emu.phase_init_in;
        end else if (step) begin
            phase_d = emu.rotate_direction_in ? (phase_q - DELTA) : (phase_q + DELTA);
        end
        hall_d = hallFromPhase(phase_d);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            hall_q  <= HALL_RESET;
        end else begin
            phase_q <= phase_d;
            hall_q  <= hall_d;
        end
    end

    assign emu.hall_u_out            = hall_q[2];
    assign emu.hall_v_out            = hall_q[1];
    assign emu.hall_w_out            = hall_q[0];
    assign emu.heds_9040_a_out       = quad_a;
    assign emu.heds_9040_b_out       = quad_b;
    assign emu.heds_9040_decoder_out = decoder;
    assign emu.heds_9040_index_out   = index;
    assign emu.model_phase_out       = {phase_q[PHASE_WIDTH-1], phase_q[PHASE_WIDTH-1], phase_q};
    assign emu.step_strobe_out       = strobe;

endmodule

// File: tb/tb_pmsm_position_sensor_emulator_module.sv
// Self-checking bench for the position-sensor emulator against an
// arithmetic model of angle, mechanical count and quadrature position.
module tb_pmsm_position_sensor_emulator_module;
    import pmsm_position_sensor_emulator_module_pkg::*;

    localparam int DELTA = 16;
    localparam int MECH_STEPS = 4096;
    localparam int TURN = 16384;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    pmsm_position_sensor_emulator_module_if #(.PERIOD_WIDTH(24)) emu();

    pmsm_position_sensor_emulator_module #(
        .POLE_PAIRS   (4),
        .CODER_CPR    (1024),
        .PERIOD_WIDTH (24)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .emu     (emu)
    );

    int checks = 0;
    int failures = 0;

    int mPhase, mMech, mQuadPos, mElapsed;
    bit mDecoder, mStrobe;
    bit [1:0] quadSeq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [2:0] hallRef(input int p);
        if (p < 'h0AAA) return 3'b101;
        if (p < 'h1555) return 3'b100;
        if (p < 'h2000) return 3'b110;
        if (p < 'h2AAA) return 3'b010;
        if (p < 'h3555) return 3'b011;
        return 3'b001;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        mPhase = 0; mMech = 0; mQuadPos = 0; mElapsed = 0;
        mDecoder = 1'b0; mStrobe = 1'b0;
    endtask

    task automatic applyStimulus(input bit en, input bit dir, input int per, input bit load, input int init);
        emu.emulator_enable_in  = en;
        emu.rotate_direction_in = dir;
        emu.step_period_in      = 24'(per);
        emu.phase_load_in       = load;
        emu.phase_init_in       = 14'(init);
    endtask

    // One clock edge of the reference: load wins, otherwise a step is due once period-1 cycles have elapsed.
    task automatic updateModel();
        int per;
        per = int'(emu.step_period_in);
        mStrobe = 1'b0;
        if (emu.phase_load_in) begin
            mPhase = int'(emu.phase_init_in);
            mMech = 0;
            mElapsed = 0;
        end else if (emu.emulator_enable_in && per != 0) begin
            if (mElapsed == per - 1) begin
                mElapsed = 0;
                mStrobe = 1'b1;
                mDecoder = ~mDecoder;
                if (!emu.rotate_direction_in) begin
                    mPhase = (mPhase + DELTA) % TURN;
                    mMech = (mMech + 1) % MECH_STEPS;
                    mQuadPos = (mQuadPos + 1) % 4;
                end else begin
                    mPhase = (mPhase + TURN - DELTA) % TURN;
                    mMech = (mMech + MECH_STEPS - 1) % MECH_STEPS;
                    mQuadPos = (mQuadPos + 3) % 4;
                end
            end else if (mElapsed >= per) begin
                mElapsed = 0;
            end else begin
                mElapsed++;
            end
        end
    endtask

    function automatic logic [15:0] phaseWord(input int p);
        logic [13:0] p14;
        p14 = 14'(p);
        return {p14[13], p14[13], p14};
    endfunction

    task automatic compareAll();
        checkOutput("model_phase", 32'(emu.model_phase_out), 32'(phaseWord(mPhase)));
        checkOutput("hall_uvw", 32'({emu.hall_u_out, emu.hall_v_out, emu.hall_w_out}), 32'(hallRef(mPhase)));
        checkOutput("quad_ab", 32'({emu.heds_9040_a_out, emu.heds_9040_b_out}), 32'(quadSeq[mQuadPos]));
        checkOutput("decoder", 32'(emu.heds_9040_decoder_out), 32'(mDecoder));
        checkOutput("index", 32'(emu.heds_9040_index_out), 32'(mMech == 0));
        checkOutput("strobe", 32'(emu.step_strobe_out), 32'(mStrobe));
    endtask

    task automatic advanceCycle();
        @(posedge sys_clk);
        updateModel();
        #1;
        compareAll();
    endtask

    function automatic logic [31:0] hallNow();
        return 32'({emu.hall_u_out, emu.hall_v_out, emu.hall_w_out});
    endfunction

    initial begin
        resetModel();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
        #12;
        compareAll();
        reset_n = 1'b1;

        // Forward at period 4: hall leaves sector 101 at step 171.
        applyStimulus(1'b1, 1'b0, 4, 1'b0, 0);
        repeat (680) advanceCycle();
        checkOutput("hall_step170", hallNow(), 32'h5);
        repeat (4) advanceCycle();
        checkOutput("phase_step171", 32'(emu.model_phase_out), 32'h0AB0);
        checkOutput("hall_step171", hallNow(), 32'h4);

        // Forward wrap through zero at period 1.
        applyStimulus(1'b1, 1'b0, 1, 1'b1, 'h3FF0);
        advanceCycle();
        checkOutput("load_phase", 32'(emu.model_phase_out), 32'hFFF0);
        checkOutput("load_hall", hallNow(), 32'h1);
        applyStimulus(1'b1, 1'b0, 1, 1'b0, 0);
        advanceCycle();
        checkOutput("wrap_phase", 32'(emu.model_phase_out), 32'h0000);
        checkOutput("wrap_hall", hallNow(), 32'h5);
        checkOutput("wrap_ab0", 32'({emu.heds_9040_a_out, emu.heds_9040_b_out}), 32'h0);
        advanceCycle();
        checkOutput("wrap_ab1", 32'({emu.heds_9040_a_out, emu.heds_9040_b_out}), 32'h2);
        advanceCycle();
        checkOutput("wrap_ab2", 32'({emu.heds_9040_a_out, emu.heds_9040_b_out}), 32'h3);
        advanceCycle();
        checkOutput("wrap_ab3", 32'({emu.heds_9040_a_out, emu.heds_9040_b_out}), 32'h1);

        // Reverse from zero: angle and mechanical count both wrap downward.
        applyStimulus(1'b1, 1'b1, 1, 1'b1, 0);
        advanceCycle();
        checkOutput("rev_load_index", 32'(emu.heds_9040_index_out), 32'h1);
        applyStimulus(1'b1, 1'b1, 1, 1'b0, 0);
        advanceCycle();
        checkOutput("rev_phase", 32'(emu.model_phase_out), 32'hFFF0);
        checkOutput("rev_hall", hallNow(), 32'h1);
        checkOutput("rev_index_low", 32'(emu.heds_9040_index_out), 32'h0);
        repeat (4095) advanceCycle();
        checkOutput("rev_rev_index", 32'(emu.heds_9040_index_out), 32'h1);
        checkOutput("rev_rev_phase", 32'(emu.model_phase_out), 32'h0000);

        // Period shrinks from 10 to 3 with the timer already at 5.
        applyStimulus(1'b1, 1'b0, 10, 1'b1, 'h1000);
        advanceCycle();
        applyStimulus(1'b1, 1'b0, 10, 1'b0, 0);
        repeat (5) advanceCycle();
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 0);
        advanceCycle();
        checkOutput("shrink_no_step", 32'(emu.step_strobe_out), 32'h0);
        advanceCycle();
        advanceCycle();
        checkOutput("shrink_pre_step", 32'(emu.step_strobe_out), 32'h0);
        advanceCycle();
        checkOutput("shrink_step", 32'(emu.step_strobe_out), 32'h1);
        checkOutput("shrink_phase", 32'(emu.model_phase_out), 32'h1010);

        // Freeze mid-interval, then resume from the held timer value.
        applyStimulus(1'b1, 1'b0, 5, 1'b0, 0);
        repeat (7) advanceCycle();
        applyStimulus(1'b0, 1'b0, 5, 1'b0, 0);
        repeat (20) advanceCycle();
        applyStimulus(1'b1, 1'b0, 5, 1'b0, 0);
        repeat (12) advanceCycle();

        // Randomized enable, direction, period and occasional loads.
        for (int i = 0; i < 3000; i++) begin
            bit en, dir, load;
            int per, init;
            en   = ($urandom_range(0, 9) != 0);
            dir  = (i / 300) % 2 == 1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            per  = (i % 40 < 20) ? int'($urandom_range(0, 6)) : int'(emu.step_period_in);
            load = ($urandom_range(0, 49) == 0);
            init = int'($urandom_range(0, 16383));
            if (i % 40 >= 1 && i % 40 < 20) per = int'(emu.step_period_in);
            applyStimulus(en, dir, per, load, init);
            advanceCycle();
        end

        // Asynchronous reset mid-rotation clears everything without a clock edge.
        applyStimulus(1'b1, 1'b0, 1, 1'b0, 0);
        repeat (9) advanceCycle();
        #2;
        reset_n = 1'b0;
        #1;
        resetModel();
        compareAll();
        #2;
        reset_n = 1'b1;
        repeat (10) advanceCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
